cart_bus_arbiter: RTL and testbench

CART_BUS_ARBITER -- requirements
Module: cart_bus_arbiter

---
 rtl/cart_bus_arbiter_if.sv | 25 ++
 rtl/cart_bus_arbiter.sv | 90 +++++++++
 tb/tb_cart_bus_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_arbiter_if.sv
// cart_bus_arbiter_if: core, host and physical cart bus signals of the arbiter
interface cart_bus_arbiter_if;
  logic        core_rd, core_wr, core_cs, core_idle, core_pause;
  logic [15:0] core_a;
  logic [7:0]  core_dout, core_din;
  logic        host_req, host_wr, host_busy, host_ack;
  logic [15:0] host_a;
  logic [7:0]  host_wdata, host_rdata;
  logic [15:0] bus_a;
  logic        bus_rd, bus_wr, bus_cs, bus_oe;
  logic [7:0]  bus_dout, bus_din;
  logic        grant_host;
  modport master (
    input  core_rd, core_wr, core_cs, core_idle, core_a, core_dout,
           host_req, host_wr, host_a, host_wdata, bus_din,
    output core_din, core_pause, host_busy, host_ack, host_rdata,
           bus_a, bus_rd, bus_wr, bus_cs, bus_oe, bus_dout, grant_host
  );
  modport slave (
    output core_rd, core_wr, core_cs, core_idle, core_a, core_dout,
           host_req, host_wr, host_a, host_wdata, bus_din,
    input  core_din, core_pause, host_busy, host_ack, host_rdata,
           bus_a, bus_rd, bus_wr, bus_cs, bus_oe, bus_dout, grant_host
  );
endinterface

// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter: shares the cart bus between the core and host accesses with a pause handshake
module cart_bus_arbiter #(
  parameter int T_SETUP   = 2,
  parameter int T_STROBE  = 8,
  parameter int T_HOLD    = 2,
  parameter int T_RELEASE = 16
) (
  input logic hclk,
  input logic reset,
  cart_bus_arbiter_if.master io
);
  typedef enum logic [2:0] {CORE, PAUSE_WAIT, H_IDLE, H_SETUP, H_STROBE, H_HOLD} state_t;
  state_t      state_q, state_d;
  logic [7:0]  ph_q, ph_d, wdata_q, wdata_d, rdata_q, rdata_d, din_q, din_d;
  logic [4:0]  rel_q, rel_d;
  logic [15:0] a_q, a_d;
  logic        wr_q, wr_d, drop_q, drop_d;
  logic        grant, acc, ph_end, leave, accept;
  assign grant  = state_q inside {H_IDLE, H_SETUP, H_STROBE, H_HOLD};
  assign acc    = state_q inside {H_SETUP, H_STROBE, H_HOLD};
  assign ph_end = ph_q == (state_q == H_SETUP  ? 8'(T_SETUP - 1) :
                           state_q == H_STROBE ? 8'(T_STROBE - 1) : 8'(T_HOLD - 1));
  // once the core wakes up during a grant, hand the bus back at the next idle point
  assign leave  = drop_q | ~io.core_idle;
  assign accept = io.host_req && (state_q == CORE || state_q == H_IDLE);
  always_comb begin
    state_d = state_q;
    ph_d    = acc ? (ph_end ? 8'd0 : ph_q + 8'd1) : 8'd0;
    rel_d   = 5'd0;
    a_d     = accept ? io.host_a : a_q;
    wr_d    = accept ? io.host_wr : wr_q;
    wdata_d = accept ? io.host_wdata : wdata_q;
    rdata_d = rdata_q;
    din_d   = grant ? din_q : io.bus_din;
    drop_d  = grant & leave;
    case (state_q)
      CORE:       state_d = io.host_req ? PAUSE_WAIT : CORE;
      PAUSE_WAIT: state_d = (io.core_idle && !io.core_rd && !io.core_wr) ? H_SETUP : PAUSE_WAIT;
      H_IDLE: begin
        rel_d   = rel_q + 5'd1;
        state_d = leave ? (io.host_req ? PAUSE_WAIT : CORE) :
                  io.host_req ? H_SETUP :
                  rel_q == 5'(T_RELEASE - 1) ? CORE : H_IDLE;
        if (leave || io.host_req) rel_d = 5'd0;
      end
      H_SETUP:  state_d = ph_end ? H_STROBE : H_SETUP;
      H_STROBE: begin
        state_d = ph_end ? H_HOLD : H_STROBE;
        if (ph_end && !wr_q) rdata_d = io.bus_din;
      end
      H_HOLD:   state_d = ph_end ? H_IDLE : H_HOLD;
      default:  state_d = CORE;
    endcase
  end
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q <= CORE;
      ph_q    <= '0;
      rel_q   <= '0;
      a_q     <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rel_q   <= rel_d;
      a_q     <= a_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      drop_q  <= drop_d;
    end
  end
  assign io.bus_a      = grant ? a_q : io.core_a;
  assign io.bus_cs     = acc ? (a_q[15:13] == 3'b101) : (grant ? 1'b0 : io.core_cs);
  assign io.bus_rd     = grant ? (state_q == H_STROBE && !wr_q) : io.core_rd;
  assign io.bus_wr     = grant ? (state_q == H_STROBE && wr_q) : io.core_wr;
  assign io.bus_dout   = grant ? wdata_q : io.core_dout;
  assign io.bus_oe     = grant ? (acc & wr_q) : io.core_wr;
  assign io.core_din   = grant ? din_q : io.bus_din;
  assign io.core_pause = state_q != CORE;
  assign io.grant_host = grant;
  assign io.host_ack   = state_q == H_HOLD && ph_end;
  assign io.host_busy  = (state_q == PAUSE_WAIT || acc) && !io.host_ack;
  assign io.host_rdata = rdata_q;
endmodule

// File: tb/tb_cart_bus_arbiter.sv
// tb_cart_bus_arbiter: directed and randomized checks against a transaction-timeline model
module tb_cart_bus_arbiter;
  localparam int TS = 2, TSTB = 8, TH = 2, TR = 16, TOT = TS + TSTB + TH;
  logic hclk = 1'b0, reset;
  int total = 0, bad = 0;
  cart_bus_arbiter_if io();
  cart_bus_arbiter dut (.hclk(hclk), .reset(reset), .io(io));
  always #5 hclk = ~hclk;
  // model: own 0=core 1=waiting for pause 2=host; t = cycle index within an access, -1 when idle
  int own, t, idle;
  bit drop;
  logic mwr;
  logic [15:0] ma;
  logic [7:0] mwd, mrd, mdin;
  logic e_g, e_acc, e_stb, e_ack;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic mreset();
    own = 0; t = -1; idle = 0; drop = 0; mrd = 0; mdin = 0;
  endtask
  task automatic mlatch();
    ma = io.host_a; mwr = io.host_wr; mwd = io.host_wdata;
  endtask
  always @(posedge hclk) begin
    if (reset) mreset();
    else begin
      if (own != 2) mdin = io.bus_din;
      if (own == 0) begin
        if (io.host_req) begin mlatch(); own = 1; end
      end else if (own == 1) begin
        if (io.core_idle && !io.core_rd && !io.core_wr) begin own = 2; t = 0; end
      end else if (t >= 0) begin
        if (!io.core_idle) drop = 1;
        if (t == TS + TSTB - 1 && !mwr) mrd = io.bus_din;
        t++;
        if (t == TOT) begin t = -1; idle = 0; end
      end else if (drop || !io.core_idle) begin
        drop = 0;
        own = io.host_req ? 1 : 0;
        if (io.host_req) mlatch();
      end else if (io.host_req) begin
        mlatch(); t = 0; idle = 0;
      end else begin
        idle++;
        if (idle == TR) own = 0;
      end
    end
  end
  always @(negedge hclk) begin
    if (reset) mreset();
    e_g = own == 2;
    e_acc = e_g && t >= 0;
    e_stb = e_acc && t >= TS && t < TS + TSTB;
    e_ack = e_acc && t == TOT - 1;
    chk("bus_a", io.bus_a, e_g ? ma : io.core_a);
    chk("bus_cs", io.bus_cs, e_acc ? 32'(ma[15:13] == 3'b101) : (e_g ? 32'd0 : 32'(io.core_cs)));
    chk("bus_rd", io.bus_rd, e_g ? (e_stb && !mwr) : io.core_rd);
    chk("bus_wr", io.bus_wr, e_g ? (e_stb && mwr) : io.core_wr);
    chk("bus_dout", io.bus_dout, e_g ? mwd : io.core_dout);
    chk("bus_oe", io.bus_oe, e_g ? (e_acc && mwr) : io.core_wr);
    chk("core_din", io.core_din, e_g ? mdin : io.bus_din);
    chk("core_pause", io.core_pause, own != 0);
    chk("grant_host", io.grant_host, e_g);
    chk("host_ack", io.host_ack, e_ack);
    chk("host_busy", io.host_busy, own == 1 || (e_acc && !e_ack));
    chk("host_rdata", io.host_rdata, mrd);
  end
  task automatic step(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask
  task automatic host_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                             output int lat, output int nrd, output int nwr, output int csbad, output int g1);
    io.host_wr = w; io.host_a = a; io.host_wdata = d; io.host_req = 1'b1;
    step(1);
    io.host_req = 1'b0;
    lat = 0; nrd = 0; nwr = 0; csbad = 0; g1 = int'(io.grant_host);
    for (int k = 1; k <= 30; k++) begin
      if (lat == 0) begin
        if (io.bus_rd || io.bus_wr) begin
          nrd += int'(io.bus_rd); nwr += int'(io.bus_wr);
          if (!io.bus_cs) csbad++;
        end
        if (io.host_ack) lat = k;
        step(1);
      end
    end
  endtask
  initial begin
    int lat, nrd, nwr, csbad, g1, n, nack;
    reset = 1'b1;
    io.core_rd = 0; io.core_wr = 0; io.core_cs = 0; io.core_idle = 0; io.core_a = 0; io.core_dout = 0;
    io.host_req = 0; io.host_wr = 0; io.host_a = 0; io.host_wdata = 0; io.bus_din = 0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_grant", io.grant_host, 0);
    chk("rst_pause", io.core_pause, 0);
    chk("rst_busy", io.host_busy, 0);
    chk("rst_rdata", io.host_rdata, 0);
    io.core_rd = 1; io.core_cs = 1; io.core_a = 16'h0150; io.bus_din = 8'hCE;
    #1;
    chk("pt_a", io.bus_a, 16'h0150);
    chk("pt_rd", io.bus_rd, 1);
    chk("pt_din", io.core_din, 8'hCE);
    chk("pt_grant", io.grant_host, 0);
    step(1);
    io.core_rd = 0; io.core_cs = 0; io.core_idle = 1; io.bus_din = 8'h5A;
    host_access(1'b0, 16'hA000, 8'h11, lat, nrd, nwr, csbad, g1);
    chk("rd_lat", lat, 13);
    chk("rd_strobes", nrd, 8);
    chk("rd_cs", csbad, 0);
    chk("rd_g1", g1, 0);
    chk("rd_data", io.host_rdata, 8'h5A);
    step(2);
    host_access(1'b1, 16'h1234, 8'h77, lat, nrd, nwr, csbad, g1);
    chk("b2b_lat", lat, 12);
    chk("b2b_wr", nwr, 8);
    chk("b2b_g1", g1, 1);
    n = 0;
    for (int k = 0; k < 40; k++) if (io.grant_host) begin n++; step(1); end
    chk("rel_cycles", n, 16);
    chk("rel_pause", io.core_pause, 0);
    io.core_idle = 0; io.core_a = 16'h0222; io.core_rd = 1;
    io.host_wr = 1; io.host_a = 16'h4000; io.host_wdata = 8'h3C; io.host_req = 1;
    step(1);
    io.host_req = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!io.core_pause || io.bus_a != 16'h0222 || !io.bus_rd || io.bus_wr || io.grant_host) n++;
      step(1);
    end
    chk("pw_hold", n, 0);
    io.core_rd = 0; io.core_idle = 1;
    #1;
    chk("pw_g0", io.grant_host, 0);
    step(1);
    chk("pw_g1", io.grant_host, 1);
    chk("pw_cs", io.bus_cs, 0);
    chk("pw_oe", io.bus_oe, 1);
    n = 0;
    while (!io.host_ack && n < 30) begin step(1); n++; end
    chk("pw_ack", io.host_ack, 1);
    step(1);
    io.host_wr = 0; io.host_a = 16'hB0F0; io.host_req = 1;
    step(1);
    io.host_req = 0;
    step(3);
    io.host_a = 16'h0001; io.host_req = 1;
    step(1);
    io.host_req = 0;
    nack = 0;
    for (int k = 0; k < 40; k++) begin nack += int'(io.host_ack); step(1); end
    chk("busy_acks", nack, 1);
    io.host_wr = 1; io.host_a = 16'hA5A5; io.host_wdata = 8'h5A; io.host_req = 1;
    step(1);
    io.host_req = 0;
    n = 0;
    while (!io.bus_wr && n < 40) begin step(1); n++; end
    chk("rs_strobe", io.bus_wr, 1);
    step(2);
    reset = 1;
    #1;
    chk("rs_wr", io.bus_wr, 0);
    chk("rs_oe", io.bus_oe, 0);
    chk("rs_grant", io.grant_host, 0);
    step(2);
    reset = 0;
    nack = 0;
    for (int k = 0; k < 20; k++) begin nack += int'(io.host_ack); step(1); end
    chk("rs_noack", nack, 0);
    chk("rs_pause", io.core_pause, 0);
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 499) == 0;
      io.host_req = $urandom_range(0, 5) == 0;
      io.host_wr = 1'($urandom);
      io.host_a = $urandom_range(0, 1) ? {3'b101, 13'($urandom)} : 16'($urandom);
      io.host_wdata = 8'($urandom);
      io.core_idle = $urandom_range(0, 19) != 0;
      io.core_rd = $urandom_range(0, 3) == 0;
      io.core_wr = $urandom_range(0, 3) == 0;
      io.core_cs = 1'($urandom);
      io.core_a = 16'($urandom);
      io.core_dout = 8'($urandom);
      io.bus_din = 8'($urandom);
      step(1);
    end
    reset = 0; io.host_req = 0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
